// File: rtl/serial_frame_rx_pkg.sv
// Shared types and constants for the framed serial receiver.
// FSM state encoding and the serial line idle level.
package serial_frame_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DATA   = 2'b01,
    PARITY = 2'b10,
    STOP   = 2'b11
  } state_t;

  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/serial_frame_rx_hold_buf.sv
// One-entry valid/ready holding buffer for received bytes, with sticky overrun flag.
// Push and pop on the same edge reload the entry; push into a full entry is dropped.
module rx_hold_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         push_perr,
  input  logic         ready,
  input  logic         clr,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         perr,
  output logic         overrun
);

  logic hs;
  logic drop;

  assign hs   = valid & ready;
  assign drop = push & valid & ~hs;

  always_ff @(posedge clk) begin
    if (rst) begin
      data    <= '0;
      valid   <= 1'b0;
      perr    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (push && !drop) begin
        data  <= push_data;
        perr  <= push_perr;
        valid <= 1'b1;
      end else if (hs) begin
        valid <= 1'b0;
      end
      // A drop on the same edge as clr keeps the flag set.
      if (drop) begin
        overrun <= 1'b1;
      end else if (clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start/data/parity/stop deframing, LSB-first, into a one-deep
// byte buffer. All state advances only on bit_stb_i; byte visible the cycle after the stop strobe.
module serial_frame_rx
  import serial_frame_rx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 D,
  input  logic                 bit_stb_i,
  input  logic                 byte_ready_i,
  input  logic                 clr_i,
  output logic [DATA_BITS-1:0] byte_o,
  output logic                 byte_valid_o,
  output logic                 par_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic ODD = (PARITY_ODD != 0);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 push;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    par_d   = par_q;
    perr_d  = perr_q;
    ferr_d  = 1'b0;
    push    = 1'b0;
    if (bit_stb_i) begin
      unique case (state_q)
        IDLE: begin
          if (D != LINE_IDLE) begin
            state_d = DATA;
            cnt_d   = '0;
            par_d   = 1'b0;
            perr_d  = 1'b0;
          end
        end
        DATA: begin
          sh_d  = {D, sh_q[DATA_BITS-1:1]};
          par_d = par_q ^ D;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          perr_d  = par_q ^ D ^ ODD;
          state_d = STOP;
        end
        STOP: begin
          // Always return to IDLE; a start bit is never taken on the stop strobe.
          state_d = IDLE;
          if (D) begin
            push = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign frame_err_o = ferr_q;
  assign busy_o      = (state_q != IDLE);

  rx_hold_buf #(
    .W(DATA_BITS)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(sh_q),
    .push_perr(perr_q),
    .ready    (byte_ready_i),
    .clr      (clr_i),
    .data     (byte_o),
    .valid    (byte_valid_o),
    .perr     (par_err_o),
    .overrun  (overrun_o)
  );

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: directed frames plus randomized frames with random
// ready/clear, checked every cycle against a transaction-level buffer model.
module tb_serial_frame_rx;

  localparam int   NB  = 8;
  localparam logic ODD = 1'b0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          D = 1'b1;
  logic          bit_stb_i = 1'b0;
  logic          byte_ready_i = 1'b1;
  logic          clr_i = 1'b0;
  logic [NB-1:0] byte_o;
  logic          byte_valid_o;
  logic          par_err_o;
  logic          frame_err_o;
  logic          overrun_o;
  logic          busy_o;

  serial_frame_rx dut (
    .clk         (clk),
    .rst         (rst),
    .D           (D),
    .bit_stb_i   (bit_stb_i),
    .byte_ready_i(byte_ready_i),
    .clr_i       (clr_i),
    .byte_o      (byte_o),
    .byte_valid_o(byte_valid_o),
    .par_err_o   (par_err_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: a completed frame either enters the one-deep buffer or is dropped.
  logic          m_valid = 1'b0;
  logic [NB-1:0] m_byte  = '0;
  logic          m_perr  = 1'b0;
  logic          m_ovr   = 1'b0;
  logic          m_ferr  = 1'b0;
  logic          push_now = 1'b0;
  logic          ferr_now = 1'b0;
  logic [NB-1:0] push_byte = '0;
  logic          push_perr = 1'b0;
  logic          rand_mode = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic tick();
    logic hs, drop, r, c;
    hs   = m_valid & byte_ready_i;
    drop = push_now & m_valid & ~hs;
    r    = rst;
    c    = clr_i;
    @(posedge clk);
    #1;
    if (r) begin
      m_valid = 1'b0; m_byte = '0; m_perr = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    end else begin
      m_ferr = ferr_now;
      if (push_now && !drop) begin
        m_valid = 1'b1; m_byte = push_byte; m_perr = push_perr;
      end else if (hs) begin
        m_valid = 1'b0;
      end
      if (drop) m_ovr = 1'b1;
      else if (c) m_ovr = 1'b0;
    end
    push_now = 1'b0;
    ferr_now = 1'b0;
    check("valid", byte_valid_o, m_valid);
    check("overrun", overrun_o, m_ovr);
    check("frame_err", frame_err_o, m_ferr);
    if (m_valid) begin
      check("byte", byte_o, m_byte);
      check("par_err", par_err_o, m_perr);
    end
    if (rand_mode) begin
      byte_ready_i = ($urandom_range(0, 2) != 0);
      clr_i        = ($urandom_range(0, 15) == 0);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic send_bit(input logic b);
    D = b;
    bit_stb_i = 1'b1;
    tick();
    bit_stb_i = 1'b0;
  endtask

  // Ends on the cycle right after the stop strobe, so callers can check latency there.
  task automatic send_frame(input logic [NB-1:0] data, input logic flip,
                            input logic stop, input int gap);
    logic pbit;
    pbit = (^data) ^ ODD ^ flip;
    send_bit(1'b0);
    idle(gap);
    for (int i = 0; i < NB; i++) begin
      send_bit(data[i]);
      idle(gap);
    end
    send_bit(pbit);
    idle(gap);
    push_byte = data;
    push_perr = (^data) ^ pbit ^ ODD;
    push_now  = stop;
    ferr_now  = ~stop;
    send_bit(stop);
  endtask

  initial begin
    logic [NB-1:0] part;

    // Reset with toggling strobes and a low line.
    rst = 1'b1; D = 1'b0;
    bit_stb_i = 1'b1; tick();
    bit_stb_i = 1'b0; tick();
    check("rst_busy", busy_o, 1'b0);
    check("rst_byte", byte_o, 8'h00);
    check("rst_perr", par_err_o, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      send_bit(1'b1);
      check("idle_busy", busy_o, 1'b0);
    end

    // Clean frame 0xA5, strobe every third cycle.
    byte_ready_i = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b1, 2);
    check("a5_valid", byte_valid_o, 1'b1);
    check("a5_byte", byte_o, 8'hA5);
    check("a5_perr", par_err_o, 1'b0);
    tick();
    check("a5_valid_1cyc", byte_valid_o, 1'b0);

    // Parity error.
    send_frame(8'h3C, 1'b1, 1'b1, 2);
    check("3c_byte", byte_o, 8'h3C);
    check("3c_perr", par_err_o, 1'b1);
    idle(2);

    // Framing error.
    send_frame(8'h55, 1'b0, 1'b0, 2);
    check("55_ferr", frame_err_o, 1'b1);
    check("55_valid", byte_valid_o, 1'b0);
    tick();
    check("55_ferr_pulse", frame_err_o, 1'b0);
    check("55_busy", busy_o, 1'b0);

    // Overrun while the consumer stalls.
    byte_ready_i = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 2);
    idle(2);
    send_frame(8'h22, 1'b0, 1'b1, 2);
    check("ovr_byte", byte_o, 8'h11);
    check("ovr_flag", overrun_o, 1'b1);
    clr_i = 1'b1; tick(); clr_i = 1'b0;
    check("ovr_clr", overrun_o, 1'b0);
    check("ovr_hold", byte_valid_o, 1'b1);
    byte_ready_i = 1'b1; tick(); byte_ready_i = 1'b0;
    check("ovr_consumed", byte_valid_o, 1'b0);

    // Reset mid-frame, then a clean frame.
    byte_ready_i = 1'b1;
    part = 8'h6B;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(part[i]);
    check("mid_busy", busy_o, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_busy", busy_o, 1'b0);
    idle(2);
    send_frame(8'h81, 1'b0, 1'b1, 2);
    check("81_byte", byte_o, 8'h81);
    check("81_perr", par_err_o, 1'b0);
    idle(2);

    // Randomized frames, gaps, ready and clear.
    rand_mode = 1'b1;
    for (int f = 0; f < 40; f++) begin
      idle($urandom_range(0, 4));
      send_frame(NB'($urandom), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 5) != 0), $urandom_range(0, 3));
      check("rand_busy", busy_o, 1'b0);
    end
    rand_mode = 1'b0;
    byte_ready_i = 1'b1;
    clr_i = 1'b0;
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
